program_loader: RTL and testbench

- Writable program store that replaces the fixed program ROM. It is the writer side of the opcode-fetch interface that the CPU reads by PC address.
- Operator enters 4-bit opcodes on the board switches and commits each one with a push-button strobe. The block clears memory, loads opcodes sequentially, then releases the CPU to run.
- Sits between the board I/O and the CPU core. The CPU fetch port (pcAddr -> opcodeOut) stays combinational, with the same timing as the ROM.

---
 rtl/program_loader_pkg.sv | 11 +
 rtl/program_loader_if.sv | 24 ++
 rtl/program_loader_strobe_sync.sv | 22 ++
 rtl/program_loader.sv | 81 ++++++++
 tb/tb_program_loader.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding and default widths for the program store
package program_loader_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_e;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: board/CPU side signals of the writable program store
interface program_loader_if #(
  parameter int ADDR_WIDTH = program_loader_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = program_loader_pkg::DATA_WIDTH
);
  logic                  loadReq;
  logic                  endLoad;
  logic                  writeStrobe;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [ADDR_WIDTH-1:0] pcAddr;
  logic [DATA_WIDTH-1:0] opcodeOut;
  logic                  cpuHold;
  logic [ADDR_WIDTH-1:0] loadAddr;
  logic                  loadDone;
  logic                  full;
  modport slave (
    input  loadReq, endLoad, writeStrobe, dataIn, pcAddr,
    output opcodeOut, cpuHold, loadAddr, loadDone, full
  );
  modport master (
    output loadReq, endLoad, writeStrobe, dataIn, pcAddr,
    input  opcodeOut, cpuHold, loadAddr, loadDone, full
  );
endinterface

// File: rtl/program_loader_strobe_sync.sv
// program_loader_strobe_sync: two-flop synchroniser plus rising-edge detect for the push-button
module program_loader_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic strobe_i,
  output logic pulse_o
);
  logic sync1_q, sync2_q, prev_q;
  // Bring the raw button into the clk domain and remember the last synced value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= strobe_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end
  assign pulse_o = sync2_q & ~prev_q;
endmodule

// File: rtl/program_loader.sv
// program_loader: clear/load/run program store feeding the CPU opcode fetch port
module program_loader #(
  parameter int ADDR_WIDTH = program_loader_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = program_loader_pkg::DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);
  import program_loader_pkg::*;
  localparam int DEPTH = 2**ADDR_WIDTH;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  full_q, full_d;
  logic                  wr_pulse, wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  program_loader_strobe_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_i (bus.writeStrobe),
    .pulse_o  (wr_pulse)
  );
  // Next state, load address, full flag and the single memory write port
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    full_d  = full_q;
    wr_en   = 1'b0;
    wr_data = bus.dataIn;
    unique case (state_q)
      IDLE: if (bus.loadReq) begin
        state_d = CLEAR;
        addr_d  = '0;
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_data = '0;
        addr_d  = addr_q + 1'b1;
        if (&addr_q) begin
          state_d = LOAD;
          full_d  = 1'b0;
        end
      end
      LOAD: begin
        if (wr_pulse) begin
          wr_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          if (&addr_q) full_d = 1'b1;
        end
        if ((wr_pulse && &addr_q) || bus.endLoad) state_d = RUN;
      end
      RUN: if (bus.loadReq) begin
        state_d = CLEAR;
        addr_d  = '0;
        full_d  = 1'b0;
      end
    endcase
  end
  // Control state; memory contents deliberately survive reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
    end
  end
  // Program memory write port
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr_q] <= wr_data;
  end
  assign bus.opcodeOut = mem_q[bus.pcAddr];
  assign bus.cpuHold   = state_q != RUN;
  assign bus.loadDone  = state_q == RUN;
  assign bus.loadAddr  = addr_q;
  assign bus.full      = full_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for the program store
module tb_program_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  program_loader_if bus ();
  program_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [7:0] a, output logic [3:0] d);
    bus.pcAddr = a;
    #1;
    d = bus.opcodeOut;
  endtask
  task automatic press(input logic [3:0] d, input int hold);
    bus.dataIn = d;
    bus.writeStrobe = 1'b1;
    repeat (hold) tick();
    bus.writeStrobe = 1'b0;
    repeat (3) tick();
  endtask
  task automatic do_clear(input string tag);
    int hold_low;
    int nonzero;
    logic [3:0] d;
    bus.loadReq = 1'b1;
    tick();
    bus.loadReq = 1'b0;
    check({tag, "_hold_next"}, bus.cpuHold, 1);
    check({tag, "_full_cleared"}, bus.full, 0);
    hold_low = 0;
    repeat (255) begin
      if (!bus.cpuHold || bus.loadDone) hold_low++;
      tick();
    end
    check({tag, "_addr255"}, bus.loadAddr, 255);
    tick();
    check({tag, "_hold_during"}, hold_low, 0);
    check({tag, "_load_addr0"}, bus.loadAddr, 0);
    check({tag, "_load_hold"}, bus.cpuHold, 1);
    nonzero = 0;
    for (int a = 0; a < 256; a++) begin
      rd(8'(a), d);
      if (d !== 4'h0) nonzero++;
    end
    check({tag, "_reads_zero"}, nonzero, 0);
  endtask
  initial begin
    logic [3:0] d;
    bus.loadReq = 1'b0;
    bus.endLoad = 1'b0;
    bus.writeStrobe = 1'b0;
    bus.dataIn = 4'h0;
    bus.pcAddr = 8'h00;
    #12;
    check("rst_hold", bus.cpuHold, 1);
    check("rst_done", bus.loadDone, 0);
    check("rst_addr", bus.loadAddr, 0);
    check("rst_full", bus.full, 0);
    reset = 1'b1;
    tick();
    do_clear("clr1");
    bus.dataIn = 4'hA;
    bus.writeStrobe = 1'b1;
    tick();
    tick();
    check("wr_edge2_none", bus.loadAddr, 0);
    tick();
    check("wr_edge3_commit", bus.loadAddr, 1);
    repeat (7) tick();
    check("wr_held_once", bus.loadAddr, 1);
    bus.writeStrobe = 1'b0;
    repeat (3) tick();
    press(4'h3, 10);
    press(4'hF, 10);
    bus.endLoad = 1'b1;
    tick();
    bus.endLoad = 1'b0;
    check("end_addr", bus.loadAddr, 3);
    check("end_hold", bus.cpuHold, 0);
    check("end_done", bus.loadDone, 1);
    rd(8'd0, d); check("rd0", d, 4'hA);
    rd(8'd1, d); check("rd1", d, 4'h3);
    rd(8'd2, d); check("rd2", d, 4'hF);
    rd(8'd3, d); check("rd3", d, 4'h0);
    press(4'h9, 2);
    check("run_strobe_ignored", bus.loadAddr, 3);
    bus.endLoad = 1'b1;
    tick();
    bus.endLoad = 1'b0;
    check("run_endload_ignored", bus.loadDone, 1);
    do_clear("clr2");
    for (int a = 0; a < 255; a++) press(4'(a), 1);
    check("pre_last_addr", bus.loadAddr, 255);
    check("pre_last_full", bus.full, 0);
    check("pre_last_done", bus.loadDone, 0);
    press(4'hF, 1);
    check("last_full", bus.full, 1);
    check("last_run", bus.loadDone, 1);
    check("last_addr", bus.loadAddr, 0);
    rd(8'hFF, d); check("rd_ff", d, 4'hF);
    rd(8'h12, d); check("rd_12", d, 4'h2);
    do_clear("clr3");
    for (int a = 0; a < 5; a++) press(4'(a + 1), 1);
    check("pre_both_addr", bus.loadAddr, 5);
    bus.dataIn = 4'h7;
    bus.writeStrobe = 1'b1;
    tick();
    tick();
    bus.endLoad = 1'b1;
    tick();
    bus.endLoad = 1'b0;
    bus.writeStrobe = 1'b0;
    check("both_addr", bus.loadAddr, 6);
    check("both_run", bus.loadDone, 1);
    rd(8'd5, d); check("both_mem5", d, 4'h7);
    rd(8'd4, d); check("both_mem4", d, 4'h5);
    repeat (3) tick();
    do_clear("clr4");
    press(4'h9, 1);
    press(4'h8, 1);
    press(4'h7, 1);
    press(4'h6, 1);
    check("pre_rst_addr", bus.loadAddr, 4);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_hold", bus.cpuHold, 1);
    check("midrst_addr", bus.loadAddr, 0);
    check("midrst_done", bus.loadDone, 0);
    tick();
    reset = 1'b1;
    rd(8'd0, d); check("keep0", d, 4'h9);
    rd(8'd1, d); check("keep1", d, 4'h8);
    rd(8'd2, d); check("keep2", d, 4'h7);
    rd(8'd3, d); check("keep3", d, 4'h6);
    rd(8'd5, d); check("keep5_cleared", d, 4'h0);
    press(4'h1, 2);
    check("idle_strobe_addr", bus.loadAddr, 0);
    rd(8'd0, d); check("idle_strobe_mem", d, 4'h9);
    bus.endLoad = 1'b1;
    tick();
    bus.endLoad = 1'b0;
    check("idle_endload", bus.loadDone, 0);
    bus.loadReq = 1'b1;
    tick();
    bus.loadReq = 1'b0;
    tick();
    check("idle_req_clear", bus.loadAddr, 1);
    check("idle_req_hold", bus.cpuHold, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
